skew_deskew_buffer: RTL and testbench
=====================================

Name: skew_deskew_buffer

Overview:
- Parametrised lane-delay buffer between the ifmap/weight staging buffers and the systolic array edges; successor to the fixed skew FIFO.
- Generalises lane count, data width and per-lane delay step.
- Adds a run-time skew/deskew mode, per-lane valid tracking, a synchronous clear, and a busy flag so the controller knows when the pipe has drained.

Parameters:
- DATA_WIDTH, 16, bit width of each signed lane element.
- NUM_LANES, 4, number of lanes (array height or width); must be >= 2.
- SKEW_STEP, 1, delay increment in enabled cycles between adjacent lanes; must be >= 1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global advance; 0 = stall, all state holds.
- clear  input  1  synchronous flush of all delay lines and valid bits.
- mode  input  1  0 = skew, 1 = deskew; sampled only when idle.
- in_valid  input  1  d_in lanes carry a valid vector this cycle.
- d_in  input  [NUM_LANES-1:0][DATA_WIDTH-1:0]  signed lane inputs.
- d_out  output  [NUM_LANES-1:0][DATA_WIDTH-1:0]  signed lane outputs.
- lane_valid  output  NUM_LANES  per-lane output valid.
- busy  output  1  any valid element in flight.
- mode_q  output  1  currently active (registered) mode.

Behaviour:
- Each lane i has a shift register of depth (NUM_LANES-1)*SKEW_STEP for data, plus a parallel valid-bit register.
- Lane delay:
  - D_i = i*SKEW_STEP when mode_q=0.
  - D_i = (NUM_LANES-1-i)*SKEW_STEP when mode_q=1.
- Output tap = stage D_i. D_i=0 is combinational passthrough: d_out[i]=d_in[i], lane_valid[i]=in_valid&en.
- Shift occurs only on cycles with en=1. Stage 0 loads d_in[i] and in_valid. When in_valid=0 a bubble (valid=0) enters and data still shifts.
- Latency: a vector accepted at enabled cycle t appears on lane i at enabled cycle t+D_i. Stall cycles do not count.
- en=0: registers hold, and registered taps hold their outputs. Zero-delay lanes show d_in with lane_valid=0.
- busy = OR of all stored valid bits across all lanes and stages. Tap position does not matter.
- Mode handling:
  - mode_q <= mode on any clock where busy=0 and in_valid=0 (idle), independent of en.
  - Otherwise mode_q holds, so a mode change while busy takes effect after drain.
  - The new mode applies to the following cycle.
- clear=1: all data stages <= 0 and all valid bits <= 0 next cycle, regardless of en. The input that cycle is discarded. mode_q follows the idle rule evaluated as idle.
- Priority: rst > clear > en.
- Reset values: all data stages 0, valid bits 0, mode_q 0. Consequently d_out 0 on registered lanes, lane_valid 0, busy 0.
- No backpressure: downstream must accept on lane_valid. Overflow is impossible because depth is fixed by construction.
- Width: data passes unmodified (no arithmetic). Signed type is preserved.

Optional Feature:
- Macro: SKEW_DESKEW_ZERO_FILL_EN.
- Defined: d_out[i] is forced to 0 whenever lane_valid[i]=0, so the array sees zeros for bubbles and stalls. This includes zero-delay lanes during en=0.
- Undefined: d_out[i] is the raw tap contents (stale or bubble data) and only lane_valid qualifies it.

Test Plan (NUM_LANES=4, SKEW_STEP=1, zero-fill off unless stated):
- Skew basic:
  - Stimulus: rst, then mode=0, en=1, in_valid=1 for 3 cycles with d_in={1,2,3,4}, {2,3,4,5}, {3,4,5,6} (lane0..3), then in_valid=0.
  - Required: lane1 shows 2,3,4 on cycles 1..3; lane2 shows 3,4,5 on cycles 2..4; lane3 shows 4,5,6 on cycles 3..5.
  - busy falls the cycle after lane3 outputs 6.
- Deskew:
  - Stimulus: idle, mode=1, one cycle idle, then vector {10,20,30,40}.
  - Required: lane3 outputs 40 the same cycle; lane2 outputs 30 at +1; lane1 outputs 20 at +2; lane0 outputs 10 at +3; mode_q=1 throughout.
- Stall:
  - Stimulus: during the skew run, drop en for 2 cycles after the second vector.
  - Required: all registered taps hold; lane3 output 4 appears exactly 2 cycles later than without the stall; lane_valid[0]=0 during the stall.
- Mode change while busy:
  - Stimulus: assert mode=1 one cycle after a vector enters in skew mode.
  - Required: mode_q stays 0 until busy=0, then becomes 1 the next clock.
- Clear mid-flight:
  - Stimulus: pulse clear with en=0 while lanes 2 and 3 hold valid data.
  - Required: next cycle all lane_valid=0, busy=0, registered d_out=0; a rst pulse gives the same result.
- Zero-fill build:
  - Stimulus: with SKEW_DESKEW_ZERO_FILL_EN defined, rerun the skew basic case.
  - Required: d_out=0 on every lane/cycle where lane_valid=0, including lane0 when en=0 with d_in[0]=7.

Source files
------------

// File: rtl/skew_deskew_buffer.sv
// rtl/skew_deskew_buffer.sv - per-lane skew/deskew delay buffer feeding systolic array edges (optional SKEW_DESKEW_ZERO_FILL_EN)
module skew_deskew_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int SKEW_STEP  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 clear,
    input  logic                                 mode,
    input  logic                                 in_valid,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] d_in,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] d_out,
    output logic [NUM_LANES-1:0]                 lane_valid,
    output logic                                 busy,
    output logic                                 mode_q
);

    // Every lane carries the full depth so either mode can be selected at run time.
    localparam int DEPTH = (NUM_LANES - 1) * SKEW_STEP;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Stage k of a lane holds the input accepted k+1 enabled cycles ago.
    // Data bits are carried untouched, so the signed interpretation is preserved.
    logic [NUM_LANES-1:0][DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_LANES-1:0][DEPTH-1:0]                 valid_q, valid_d;
    logic                                            mode_d;

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] tap_data;
    logic [NUM_LANES-1:0]                 tap_valid;
    int                                   dly;
    logic [IDX_W-1:0]                     tap_idx;

    // Anything stored counts as in flight, regardless of which stage is tapped.
    assign busy = |valid_q;

    // Next state: clear flushes everything, en shifts, mode latches only while idle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        if (clear) begin
            data_d  = '0;
            valid_d = '0;
            mode_d  = mode;
        end else begin
            if (en) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        data_d[i][k]  = data_q[i][k-1];
                        valid_d[i][k] = valid_q[i][k-1];
                    end
                    data_d[i][0]  = d_in[i];
                    valid_d[i][0] = in_valid;
                end
            end
            if (!busy && !in_valid) begin
                mode_d = mode;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
        end
    end

    // Output taps: delay grows with lane index in skew mode and shrinks in deskew mode.
    always_comb begin
        tap_data  = '0;
        tap_valid = '0;
        dly       = 0;
        tap_idx   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dly = mode_q ? (NUM_LANES - 1 - i) * SKEW_STEP : i * SKEW_STEP;
            if (dly == 0) begin
                tap_idx      = '0;
                tap_data[i]  = d_in[i];
                tap_valid[i] = in_valid & en;
            end else begin
                tap_idx      = IDX_W'(dly - 1);
                tap_data[i]  = data_q[i][tap_idx];
                tap_valid[i] = valid_q[i][tap_idx];
            end
        end
    end

    // Output qualification: optionally blank data whenever the lane is not valid.
    always_comb begin
        lane_valid = tap_valid;
        d_out      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef SKEW_DESKEW_ZERO_FILL_EN
            d_out[i] = tap_valid[i] ? tap_data[i] : '0;
`else
            d_out[i] = tap_data[i];
`endif
        end
    end

endmodule

// File: tb/tb_skew_deskew_buffer.sv
// tb/tb_skew_deskew_buffer.sv - randomized bench for skew_deskew_buffer against a history-queue model
module tb_skew_deskew_buffer;

    localparam int N = 4;
    localparam int W = 16;
    localparam int S = 1;
    localparam int DEPTH = (N - 1) * S;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        logic v;
        vec_t d;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst, en, clear, mode, in_valid;
    vec_t         d_in, d_out;
    logic [N-1:0] lane_valid;
    logic         busy, mode_q;

    int checks = 0;
    int errors = 0;

    // Model: hist[k] is the input accepted k+1 enabled cycles ago.
    ent_t hist[$];
    logic m_mode;

    skew_deskew_buffer #(.DATA_WIDTH(W), .NUM_LANES(N), .SKEW_STEP(S)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode),
        .in_valid(in_valid), .d_in(d_in), .d_out(d_out),
        .lane_valid(lane_valid), .busy(busy), .mode_q(mode_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
        vec_t r;
        r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3);
        return r;
    endfunction

    function automatic logic m_busy();
        for (int k = 0; k < hist.size(); k++) if (hist[k].v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_flush();
        ent_t z;
        z.v = 1'b0;
        z.d = '0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(z);
    endfunction

    // One clock: drive, compare on the falling edge, then advance the model on the rising edge.
    task automatic step(input logic v, input logic e, input logic c, input logic m, input vec_t din);
        logic  bsy;
        logic  ev;
        logic [W-1:0] ed;
        int    dl;
        ent_t  ne;
        in_valid = v; en = e; clear = c; mode = m; d_in = din;
        @(negedge clk);
        bsy = m_busy();
        chk("busy", busy, bsy);
        chk("mode_q", mode_q, m_mode);
        for (int i = 0; i < N; i++) begin
            dl = m_mode ? (N - 1 - i) * S : i * S;
            if (dl == 0) begin
                ev = v & e;
                ed = din[i];
            end else begin
                ev = hist[dl-1].v;
                ed = hist[dl-1].d[i];
            end
`ifdef SKEW_DESKEW_ZERO_FILL_EN
            if (!ev) ed = '0;
`endif
            chk($sformatf("lane%0d_valid", i), lane_valid[i], ev);
            chk($sformatf("lane%0d_data", i), d_out[i], ed);
        end
        @(posedge clk);
        if (c) begin
            m_flush();
            m_mode = m;
        end else begin
            if (e) begin
                ne.v = v;
                ne.d = din;
                hist.push_front(ne);
                void'(hist.pop_back());
            end
            if (!bsy && !v) m_mode = m;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = $urandom_range(0, 1);
        en = $urandom_range(0, 1);
        clear = 1'b0;
        mode = $urandom_range(0, 1);
        d_in = vec_t'({$urandom, $urandom});
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_flush();
        m_mode = 1'b0;
        in_valid = 1'b0; en = 1'b0; mode = 1'b0; d_in = '0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mode", mode_q, 1'b0);
        chk("rst_valid", lane_valid, '0);
        chk("rst_dout", d_out, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; d_in = '0;
        m_flush();
        m_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Skew basic, with a two-cycle stall after the second vector.
        step(1, 1, 0, 0, mk(1, 2, 3, 4));
        step(1, 1, 0, 0, mk(2, 3, 4, 5));
        step(1, 0, 0, 0, mk(7, 0, 0, 0));
        step(1, 0, 0, 1, mk(7, 0, 0, 0));
        step(1, 1, 0, 1, mk(3, 4, 5, 6));
        repeat (5) step(0, 1, 0, 1, mk(9, 9, 9, 9));
        chk("mode_after_drain", mode_q, 1'b1);

        // Deskew: lane3 passes through, lane0 waits the longest.
        step(0, 1, 0, 1, '0);
        step(1, 1, 0, 1, mk(10, 20, 30, 40));
        repeat (4) step(0, 1, 0, 1, '0);

        // Back to skew, then clear with en low while lanes 2 and 3 hold data.
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, mk(1, 2, 3, 4));
        step(1, 1, 0, 0, mk(2, 3, 4, 5));
        step(0, 0, 1, 0, mk(5, 5, 5, 5));
        step(0, 1, 0, 0, '0);
        chk("clear_busy", busy, 1'b0);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6,
                     $urandom_range(0, 9) < 8,
                     $urandom_range(0, 49) == 0,
                     ($urandom_range(0, 19) == 0) ? ~mode : mode,
                     vec_t'({$urandom, $urandom}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
